mvu_datamover: RTL and testbench



---
 rtl/mvu_datamover.sv | 200 ++++++++++++++++++++
 tb/tb_mvu_datamover.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvu_datamover.sv
// mvu_datamover: host-side block mover between host streams and one MVU's controller data-memory ports.
// Optional feature: define MVU_DATAMOVER_TIMEOUT_EN to abort commands whose grant never arrives.
module mvu_datamover #(
   parameter  int NMVU      = 8,
   parameter  int N         = 64,
   parameter  int BDBANKA   = 15,
   parameter  int RDLAT     = 2,
   parameter  int FIFODEPTH = 4,
   parameter  int TIMEOUT   = 255,
   localparam int BMVUA     = $clog2(NMVU)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_dir,
   input  logic [BMVUA-1:0]        cmd_mvu,
   input  logic [BDBANKA-1:0]      cmd_addr,
   input  logic [BDBANKA-1:0]      cmd_len,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [N-1:0]            wr_data,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [N-1:0]            rd_data,
   output logic                    done,
   output logic                    err,
   output logic [NMVU-1:0]         rdc_en,
   input  logic [NMVU-1:0]         rdc_grnt,
   output logic [NMVU*BDBANKA-1:0] rdc_addr,
   input  logic [NMVU*N-1:0]       rdc_word,
   output logic [NMVU-1:0]         wrc_en,
   input  logic [NMVU-1:0]         wrc_grnt,
   output logic [BDBANKA-1:0]      wrc_addr,
   output logic [N-1:0]            wrc_word
);

   localparam int PW   = $clog2(FIFODEPTH);
   localparam int CNTW = PW + 1;
   localparam int CRW  = PW + 2;

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

   state_e             state_q, state_d;
   logic [BMVUA-1:0]   mvu_q, mvu_d;
   logic [BDBANKA-1:0] addr_q, addr_d;
   logic [BDBANKA-1:0] rem_q, rem_d;
   logic [RDLAT-1:0]   pipe_q, pipe_d;
   logic [N-1:0]       fifo_q [FIFODEPTH];
   logic [N-1:0]       fifo_d [FIFODEPTH];
   logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNTW-1:0]    cnt_q, cnt_d;
   logic               done_q, done_d;

   logic [NMVU-1:0]    sel;
   logic [CRW-1:0]     inflight;
   logic               credit_ok, rd_req, rd_beat, wr_beat, push, pop;
   logic [N-1:0]       ret_word;

   assign sel       = NMVU'(1) << mvu_q;
   assign ret_word  = rdc_word[mvu_q*N +: N];
   // Credit covers both words still in the return pipe and words parked in the FIFO.
   assign credit_ok = (inflight + CRW'(cnt_q)) < CRW'(FIFODEPTH);
   assign rd_req    = (state_q == READ) && credit_ok;
   assign rd_beat   = rd_req && rdc_grnt[mvu_q];
   assign wr_beat   = (state_q == WRITE) && wr_valid && wrc_grnt[mvu_q];
   assign push      = pipe_q[RDLAT-1];
   assign pop       = rd_valid && rd_ready;

   assign cmd_ready = (state_q == IDLE);
   assign done      = done_q;
   assign rdc_en    = rd_req ? sel : '0;
   assign rdc_addr  = {NMVU{addr_q}};
   assign wrc_en    = ((state_q == WRITE) && wr_valid) ? sel : '0;
   assign wr_ready  = (state_q == WRITE) && wrc_grnt[mvu_q];
   assign wrc_addr  = addr_q;
   assign wrc_word  = (state_q == WRITE) ? wr_data : '0;
   assign rd_valid  = (cnt_q != '0);
   assign rd_data   = fifo_q[rptr_q];

`ifdef MVU_DATAMOVER_TIMEOUT_EN
   localparam int TOW = $clog2(TIMEOUT + 1);
   logic [TOW-1:0] to_q, to_d;
   logic           err_q, err_d;
   logic           stall;
   assign stall = (rd_req && !rdc_grnt[mvu_q]) ||
                  ((state_q == WRITE) && wr_valid && !wrc_grnt[mvu_q]);
   assign err   = err_q;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < RDLAT; i++) inflight = inflight + CRW'(pipe_q[i]);
   end

   always_comb begin
      state_d = state_q;
      mvu_d   = mvu_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      pipe_d  = pipe_q << 1;
      pipe_d[0] = rd_beat;
      fifo_d  = fifo_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      cnt_d   = cnt_q + CNTW'(push) - CNTW'(pop);
      if (push) begin
         fifo_d[wptr_q] = ret_word;
         wptr_d = wptr_q + PW'(1);
      end
      if (pop) rptr_d = rptr_q + PW'(1);

      case (state_q)
         IDLE: if (cmd_valid) begin
            mvu_d  = cmd_mvu;
            addr_d = cmd_addr;
            rem_d  = cmd_len;
            if (cmd_len == '0) done_d = 1'b1;
            else               state_d = cmd_dir ? READ : WRITE;
         end
         WRITE: if (wr_beat) begin
            addr_d = addr_q + BDBANKA'(1);
            rem_d  = rem_q - BDBANKA'(1);
            if (rem_q == BDBANKA'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         READ: if (rd_beat) begin
            addr_d = addr_q + BDBANKA'(1);
            rem_d  = rem_q - BDBANKA'(1);
            if (rem_q == BDBANKA'(1)) state_d = DRAIN;
         end
         DRAIN: if ((cnt_d == '0) && (pipe_d == '0)) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase

`ifdef MVU_DATAMOVER_TIMEOUT_EN
      err_d = 1'b0;
      to_d  = to_q;
      if ((state_q == IDLE) || wr_beat || rd_beat) begin
         to_d = '0;
      end else if (stall) begin
         if (to_q == TOW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            to_d    = '0;
            pipe_d  = '0;
            cnt_d   = '0;
            wptr_d  = '0;
            rptr_d  = '0;
         end else begin
            to_d = to_q + TOW'(1);
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mvu_q   <= '0;
         addr_q  <= '0;
         rem_q   <= '0;
         pipe_q  <= '0;
         fifo_q  <= '{default: '0};
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
`ifdef MVU_DATAMOVER_TIMEOUT_EN
         to_q    <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         mvu_q   <= mvu_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         pipe_q  <= pipe_d;
         fifo_q  <= fifo_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
`ifdef MVU_DATAMOVER_TIMEOUT_EN
         to_q    <= to_d;
         err_q   <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_mvu_datamover.sv
// Directed bench for mvu_datamover: write, read with backpressure, wrap, zero length, stalls, reset, timeout.
`timescale 1ns/1ps
module tb_mvu_datamover;

   localparam int NMVU = 8, N = 64, BA = 15, RDLAT = 2, FD = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 cmd_valid, cmd_ready, cmd_dir;
   logic [2:0]           cmd_mvu;
   logic [BA-1:0]        cmd_addr, cmd_len;
   logic                 wr_valid, wr_ready;
   logic [N-1:0]         wr_data;
   logic                 rd_valid, rd_ready;
   logic [N-1:0]         rd_data;
   logic                 done, err;
   logic [NMVU-1:0]      rdc_en, rdc_grnt, wrc_en, wrc_grnt;
   logic [NMVU*BA-1:0]   rdc_addr;
   logic [NMVU*N-1:0]    rdc_word;
   logic [BA-1:0]        wrc_addr;
   logic [N-1:0]         wrc_word;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mvu_datamover #(.NMVU(NMVU), .N(N), .BDBANKA(BA), .RDLAT(RDLAT), .FIFODEPTH(FD), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir), .cmd_mvu(cmd_mvu),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .done(done), .err(err),
      .rdc_en(rdc_en), .rdc_grnt(rdc_grnt), .rdc_addr(rdc_addr), .rdc_word(rdc_word),
      .wrc_en(wrc_en), .wrc_grnt(wrc_grnt), .wrc_addr(wrc_addr), .wrc_word(wrc_word)
   );

   // Memory contents encode the MVU index and word address they came from.
   function automatic logic [63:0] mdata(input int m, input int a);
      return {16'hC0DE, 16'(m), 17'b0, 15'(a)};
   endfunction

   function automatic int oh_idx(input logic [NMVU-1:0] v);
      int r = 0;
      for (int i = 0; i < NMVU; i++) if (v[i]) r = i;
      return r;
   endfunction

   // MVU read-port model: data for a granted beat is presented RDLAT cycles later.
   logic [RDLAT-1:0] st_v = '0;
   logic [63:0]      st_d [RDLAT];
   int               st_m [RDLAT];

   always @(posedge clk) begin
      st_v[0] <= |(rdc_en & rdc_grnt);
      st_m[0] <= oh_idx(rdc_en & rdc_grnt);
      st_d[0] <= mdata(oh_idx(rdc_en & rdc_grnt), int'(rdc_addr[BA-1:0]));
      for (int i = 1; i < RDLAT; i++) begin
         st_v[i] <= st_v[i-1];
         st_m[i] <= st_m[i-1];
         st_d[i] <= st_d[i-1];
      end
   end

   always_comb begin
      rdc_word = '0;
      for (int m = 0; m < NMVU; m++)
         rdc_word[m*N +: N] = (st_v[RDLAT-1] && st_m[RDLAT-1] == m) ? st_d[RDLAT-1]
                                                                     : (64'hBAD0_0000_0000_0000 | 64'(m));
   end

   // Words outstanding in the mover (granted but not yet popped).
   int outst = 0, max_out = 0;
   always @(posedge clk) begin
      if (rst) outst = 0;
      else outst = outst + ((|(rdc_en & rdc_grnt)) ? 1 : 0) - ((rd_valid && rd_ready) ? 1 : 0);
      if (outst > max_out) max_out = outst;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input bit dir, input int m, input int a, input int n);
      cmd_valid = 1'b1;
      cmd_dir   = dir;
      cmd_mvu   = 3'(m);
      cmd_addr  = BA'(a);
      cmd_len   = BA'(n);
      #1;
      chk("cmd_ready_at_issue", 64'(cmd_ready), 64'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic read_xfer(input int m, input int a, input int n, input bit bp);
      int k = 0, last_pop = -1, done_at = -1, first_v = -1;
      issue(1'b1, m, a, n);
      #1;
      chk("rd_first_en", 64'(rdc_en), 64'(8'(1) << m));
      chk("rd_first_addr", 64'(rdc_addr === {NMVU{BA'(a)}}), 64'd1);
      for (int c = 0; c < 200; c++) begin
         if (c > 0) tick();
         if (done) begin
            done_at = c;
            break;
         end
         rd_ready = bp ? c[0] : 1'b1;
         #1;
         if (rd_valid && first_v < 0) first_v = c;
         if (rd_valid && rd_ready) begin
            chk("rd_data", rd_data, mdata(m, (a + k) % 32768));
            k++;
            last_pop = c;
         end
      end
      chk("rd_word_count", 64'(k), 64'(n));
      chk("rd_done_after_last_pop", 64'(done_at), 64'(last_pop + 1));
      chk("rd_first_valid_latency", 64'(first_v), 64'(RDLAT + 1));
      chk("rd_err", 64'(err), 64'd0);
      rd_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_mvu = '0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = 64'hFFFF; rd_ready = 1'b0; rdc_grnt = '0; wrc_grnt = '0;
      repeat (3) tick();
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      rst = 1'b0;
      tick();
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_rdc_en", 64'(rdc_en), 64'd0);
      chk("rst_wrc_en", 64'(wrc_en), 64'd0);
      chk("rst_wr_ready", 64'(wr_ready), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_wrc_addr", 64'(wrc_addr), 64'd0);
      chk("rst_rdc_addr", 64'(rdc_addr === '0), 64'd1);
      chk("rst_wrc_word", wrc_word, 64'd0);

      // Write: mvu 3, 0x10, four words
      wrc_grnt = '1; wr_valid = 1'b1; wr_data = 64'hA;
      issue(1'b0, 3, 'h10, 4);
      for (int i = 0; i < 4; i++) begin
         wr_data = 64'hA + 64'(i);
         #1;
         chk("wr_en", 64'(wrc_en), 64'h08);
         chk("wr_addr", 64'(wrc_addr), 64'h10 + 64'(i));
         chk("wr_word", wrc_word, 64'hA + 64'(i));
         chk("wr_ready", 64'(wr_ready), 64'd1);
         chk("wr_no_early_done", 64'(done), 64'd0);
         tick();
      end
      wr_valid = 1'b0;
      chk("wr_done", 64'(done), 64'd1);
      chk("wr_err", 64'(err), 64'd0);
      chk("wr_en_idle", 64'(wrc_en), 64'd0);
      chk("wr_cmd_ready", 64'(cmd_ready), 64'd1);
      tick();
      chk("wr_done_one_cycle", 64'(done), 64'd0);

      // Intermittent grant: mvu 1 grant low for 3 cycles after first beat
      wr_valid = 1'b1; wr_data = 64'h11;
      issue(1'b0, 1, 'h100, 3);
      #1;
      chk("ig_addr0", 64'(wrc_addr), 64'h100);
      tick();
      wrc_grnt = 8'hFD; wr_data = 64'h22;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("ig_hold_en", 64'(wrc_en), 64'h02);
         chk("ig_hold_addr", 64'(wrc_addr), 64'h101);
         chk("ig_hold_word", wrc_word, 64'h22);
         chk("ig_hold_ready", 64'(wr_ready), 64'd0);
         chk("ig_hold_done", 64'(done), 64'd0);
         tick();
      end
      wrc_grnt = '1;
      #1;
      chk("ig_addr1", 64'(wrc_addr), 64'h101);
      tick();
      wr_data = 64'h33;
      #1;
      chk("ig_addr2", 64'(wrc_addr), 64'h102);
      chk("ig_no_early_done", 64'(done), 64'd0);
      tick();
      wr_valid = 1'b0;
      chk("ig_done", 64'(done), 64'd1);

      // Read with backpressure, then wrap-around read
      rdc_grnt = '1;
      tick();
      read_xfer(5, 'h200, 8, 1'b1);
      chk("bp_max_outstanding", 64'(max_out), 64'd4);
      tick();
      read_xfer(2, 'h7FFE, 3, 1'b0);

      // Zero length, then back-to-back zero length accepted in the done cycle
      tick();
      issue(1'b1, 4, 'h55, 0);
      chk("z_done", 64'(done), 64'd1);
      chk("z_err", 64'(err), 64'd0);
      chk("z_rdc_en", 64'(rdc_en), 64'd0);
      chk("z_wrc_en", 64'(wrc_en), 64'd0);
      issue(1'b0, 4, 'h55, 0);
      chk("z2_done", 64'(done), 64'd1);
      tick();
      chk("z2_done_clear", 64'(done), 64'd0);

      // Reset with two reads in flight
      issue(1'b1, 6, 'h40, 8);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("mr_rdc_en", 64'(rdc_en), 64'd0);
      chk("mr_rd_valid", 64'(rd_valid), 64'd0);
      chk("mr_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("mr_done", 64'(done), 64'd0);
      rst = 1'b0;
      rd_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("mr_after_rd_valid", 64'(rd_valid), 64'd0);
         chk("mr_after_done", 64'(done), 64'd0);
      end
      rd_ready = 1'b0;

`ifdef MVU_DATAMOVER_TIMEOUT_EN
      rdc_grnt = 8'h7F;
      issue(1'b1, 7, 'h0, 2);
      chk("to_en_rise", 64'(rdc_en), 64'h80);
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i < 8) chk("to_no_early_done", 64'(done), 64'd0);
      end
      chk("to_done", 64'(done), 64'd1);
      chk("to_err", 64'(err), 64'd1);
      chk("to_rdc_en", 64'(rdc_en), 64'd0);
      chk("to_cmd_ready", 64'(cmd_ready), 64'd1);
      tick();
      chk("to_done_clear", 64'(done), 64'd0);
      chk("to_err_clear", 64'(err), 64'd0);
`else
      rdc_grnt = 8'h7F;
      issue(1'b1, 7, 'h0, 2);
      for (int i = 0; i < 12; i++) begin
         chk("wait_en_held", 64'(rdc_en), 64'h80);
         chk("wait_no_done", 64'(done), 64'd0);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("wait_err_tied", 64'(err), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
